// File: rtl/fifo_pkg.sv
// Shared defaults for the synchronous FIFO and its bench.
package fifo_pkg;

  localparam int DEF_FIFO_WIDTH = 16;
  localparam int DEF_FIFO_DEPTH = 8;

  // Pointer width; never zero so a depth-1 FIFO still gets a legal vector.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data, registered write/read status
// and combinational occupancy flags decoded from the word count.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [FIFO_WIDTH-1:0] data_in,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic [FIFO_WIDTH-1:0] data_out,
  output logic                  wr_ack,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  full,
  output logic                  almostfull,
  output logic                  empty,
  output logic                  almostempty
);

  localparam int PTR_W = ptr_width(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] AFULL_C  = CNT_W'(FIFO_DEPTH - 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  wr_ok;
  logic                  rd_ok;

  assign full        = (count == DEPTH_C);
  assign almostfull  = (count == AFULL_C);
  assign empty       = (count == '0);
  assign almostempty = (count == CNT_W'(1));

  // When full a simultaneous request reads only; when empty it writes only.
  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      data_out  <= '0;
      wr_ack    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wr_ack    <= wr_ok;
      overflow  <= wr_en && full;
      underflow <= rd_en && empty;
      if (wr_ok) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (rd_ok) begin
        data_out <= mem[rd_ptr];
        rd_ptr   <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
      end
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_sync_fifo.sv
// Scenario bench for sync_fifo: a queue scoreboard holds accepted words and
// predicts read data, status bits and occupancy flags.
module tb_sync_fifo;
  import fifo_pkg::*;

  localparam int W = DEF_FIFO_WIDTH;
  localparam int D = DEF_FIFO_DEPTH;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] data_in = '0;
  logic         wr_en = 1'b0;
  logic         rd_en = 1'b0;
  logic [W-1:0] data_out;
  logic         wr_ack, overflow, underflow;
  logic         full, almostfull, empty, almostempty;

  int unsigned tests_run = 0;
  int unsigned failed = 0;

  logic [W-1:0] q[$];
  logic [W-1:0] exp_dout = '0;
  logic         exp_ack = 1'b0;
  logic         exp_ovf = 1'b0;
  logic         exp_udf = 1'b0;
  logic [6:0]   obs_flags;

  sync_fifo #(.FIFO_WIDTH(W), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en),
    .data_out(data_out), .wr_ack(wr_ack), .overflow(overflow),
    .underflow(underflow), .full(full), .almostfull(almostfull),
    .empty(empty), .almostempty(almostempty)
  );

  always #5 clk = ~clk;

  assign obs_flags = {wr_ack, overflow, underflow, full, almostfull, empty, almostempty};

  function automatic logic [6:0] exp_flags();
    int n;
    n = q.size();
    return {exp_ack, exp_ovf, exp_udf, n == D, n == D - 1, n == 0, n == 1};
  endfunction

  // One clock of stimulus; the model is advanced from its pre-edge state.
  task automatic drive(input logic w, input logic r, input logic [W-1:0] d);
    logic m_full, m_empty;
    m_full  = (q.size() == D);
    m_empty = (q.size() == 0);
    wr_en = w; rd_en = r; data_in = d;
    exp_ack = w && !m_full;
    exp_ovf = w && m_full;
    exp_udf = r && m_empty;
    if (r && !m_empty) exp_dout = q.pop_front();
    if (exp_ack) q.push_back(d);
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    tests_run++;
    if (data_out !== '0 || empty !== 1'b1 || full !== 1'b0 || dut.count !== '0) begin
      failed++;
      $display("FAIL reset_init: data_out=%h empty=%b full=%b count=%0d want 0/1/0/0",
               data_out, empty, full, dut.count);
    end
    #9 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_fill();
    for (int i = 1; i <= D; i++) begin
      drive(1'b1, 1'b0, W'(i));
      tests_run++;
      if (wr_ack !== 1'b1 || dut.count !== 4'(i) || almostfull !== (i == D - 1) || full !== (i == D)) begin
        failed++;
        $display("FAIL fill[%0d]: ack=%b count=%0d afull=%b full=%b want 1/%0d/%b/%b",
                 i, wr_ack, dut.count, almostfull, full, i, i == D - 1, i == D);
      end
    end
    drive(1'b1, 1'b0, W'(16'h0009));
    tests_run++;
    if (overflow !== 1'b1 || wr_ack !== 1'b0 || dut.count !== 4'(D)) begin
      failed++;
      $display("FAIL fill_overflow: ovf=%b ack=%b count=%0d want 1/0/%0d",
               overflow, wr_ack, dut.count, D);
    end
    drive(1'b0, 1'b0, '0);
    tests_run++;
    if (obs_flags !== exp_flags()) begin
      failed++;
      $display("FAIL fill_idle_flags: got %b want %b", obs_flags, exp_flags());
    end
  endtask

  task automatic test_drain();
    for (int i = 1; i <= D; i++) begin
      drive(1'b0, 1'b1, '0);
      tests_run++;
      if (data_out !== W'(i) || data_out !== exp_dout || obs_flags !== exp_flags()
          || almostempty !== (D - i == 1)) begin
        failed++;
        $display("FAIL drain[%0d]: data=%h flags=%b want data=%h flags=%b",
                 i, data_out, obs_flags, W'(i), exp_flags());
      end
    end
    drive(1'b0, 1'b1, '0);
    tests_run++;
    if (underflow !== 1'b1 || data_out !== W'(16'h0008) || empty !== 1'b1) begin
      failed++;
      $display("FAIL drain_underflow: udf=%b data=%h empty=%b want 1/0008/1",
               underflow, data_out, empty);
    end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, W'(16'h0010 + i));
    for (int k = 0; k < 10; k++) begin
      logic [W-1:0] want;
      want = (k < 4) ? W'(16'h0010 + k) : W'(16'h0020 + k - 4);
      drive(1'b1, 1'b1, W'(16'h0020 + k));
      tests_run++;
      if (dut.count !== 4'd4 || data_out !== want || data_out !== exp_dout || obs_flags !== exp_flags()) begin
        failed++;
        $display("FAIL simul[%0d]: count=%0d data=%h flags=%b want 4/%h/%b",
                 k, dut.count, data_out, obs_flags, want, exp_flags());
      end
    end
    tests_run++;
    if (dut.wr_ptr !== 3'd6 || dut.rd_ptr !== 3'd2) begin
      failed++;
      $display("FAIL simul_wrap: wr_ptr=%0d rd_ptr=%0d want 6/2", dut.wr_ptr, dut.rd_ptr);
    end
  endtask

  task automatic test_boundaries();
    logic [W-1:0] held;
    while (q.size() != 0) drive(1'b0, 1'b1, '0);
    held = data_out;
    drive(1'b1, 1'b1, W'(16'hA5A5));
    tests_run++;
    if (dut.count !== 4'd1 || underflow !== 1'b1 || wr_ack !== 1'b1 || data_out !== held) begin
      failed++;
      $display("FAIL bound_empty: count=%0d udf=%b ack=%b data=%h want 1/1/1/%h",
               dut.count, underflow, wr_ack, data_out, held);
    end
    for (int k = 0; k < D - 1; k++) drive(1'b1, 1'b0, W'(16'hB000 + k));
    tests_run++;
    if (full !== 1'b1 || empty !== 1'b0) begin
      failed++;
      $display("FAIL bound_fill: full=%b empty=%b want 1/0", full, empty);
    end
    drive(1'b1, 1'b1, W'(16'hDEAD));
    tests_run++;
    if (dut.count !== 4'd7 || overflow !== 1'b1 || wr_ack !== 1'b0 || data_out !== W'(16'hA5A5)) begin
      failed++;
      $display("FAIL bound_full: count=%0d ovf=%b ack=%b data=%h want 7/1/0/a5a5",
               dut.count, overflow, wr_ack, data_out);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1200; c++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), W'($urandom));
      tests_run++;
      if (data_out !== exp_dout || obs_flags !== exp_flags() || dut.count !== 4'(q.size())) begin
        failed++;
        $display("FAIL random[%0d]: data=%h flags=%b count=%0d want %h/%b/%0d",
                 c, data_out, obs_flags, dut.count, exp_dout, exp_flags(), q.size());
      end
    end
  endtask

  task automatic test_reset_midop();
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, W'(16'h7000 + i));
    #3 rst_n = 1'b0;
    #1;
    q.delete();
    exp_dout = '0; exp_ack = 1'b0; exp_ovf = 1'b0; exp_udf = 1'b0;
    tests_run++;
    if (data_out !== '0 || dut.count !== '0 || dut.wr_ptr !== '0 || dut.rd_ptr !== '0
        || empty !== 1'b1 || full !== 1'b0 || wr_ack !== 1'b0 || overflow !== 1'b0 || underflow !== 1'b0) begin
      failed++;
      $display("FAIL reset_midop: data=%h count=%0d wp=%0d rp=%0d flags=%b want all clear, empty",
               data_out, dut.count, dut.wr_ptr, dut.rd_ptr, obs_flags);
    end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    drive(1'b1, 1'b0, W'(16'hBEEF));
    drive(1'b0, 1'b1, '0);
    tests_run++;
    if (data_out !== W'(16'hBEEF) || empty !== 1'b1 || obs_flags !== exp_flags()) begin
      failed++;
      $display("FAIL reset_first_read: data=%h empty=%b want beef/1", data_out, empty);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_simultaneous();
    test_boundaries();
    test_random();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
